// File: rtl/k_alu_result_capture.sv
// K_ALU result capture: valid/ready sink, FWFT FIFO and running statistics.
// Statistics cover every accepted result since reset or clear.
module k_alu_result_capture #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1,
    localparam int SW    = DATA_W + CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LW-1:0]     level,
    output logic [CNT_W-1:0]  stat_count,
    output logic [SW-1:0]     stat_sum,
    output logic [DATA_W-1:0] stat_min,
    output logic [DATA_W-1:0] stat_max,
    output logic              drop
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              push;
    logic              pop;

    assign res_ready = (level != LW'(DEPTH));
    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rptr] : '0;
    assign push      = res_valid && res_ready;
    assign pop       = out_valid && out_ready;

    // Storage is not reset; out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wptr] <= res_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            drop  <= 1'b0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            drop  <= 1'b0;
        end else begin
            drop <= res_valid && !res_ready;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count <= '0;
            stat_sum   <= '0;
            stat_min   <= '1;
            stat_max   <= '0;
        end else if (clear) begin
            stat_count <= '0;
            stat_sum   <= '0;
            stat_min   <= '1;
            stat_max   <= '0;
        end else if (push) begin
            if (stat_count != '1)
                stat_count <= stat_count + 1'b1;
            stat_sum <= stat_sum + {{CNT_W{1'b0}}, res_data};
            if (res_data < stat_min)
                stat_min <= res_data;
            if (res_data > stat_max)
                stat_max <= res_data;
        end
    end

endmodule

// File: tb/tb_k_alu_result_capture.sv
// Bench for k_alu_result_capture: scoreboard on FIFO output, directed stats checks.
// Inputs change 1ns after posedge; the scoreboard samples at negedge.
module tb_k_alu_result_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  level;
    logic [15:0] stat_count;
    logic [47:0] stat_sum;
    logic [31:0] stat_min;
    logic [31:0] stat_max;
    logic        drop;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    k_alu_result_capture dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .stat_count(stat_count), .stat_sum(stat_sum),
        .stat_min(stat_min), .stat_max(stat_max), .drop(drop)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        res_valid = 1'b1;
        res_data  = d;
        tick();
        res_valid = 1'b0;
    endtask

    // Scoreboard: inputs are stable at negedge, so these are the values
    // the DUT will act on at the following posedge.
    always @(negedge clk) begin
        if (!rst_n || clear) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0)
                    chk("sb_underflow", 64'd1, 64'd0);
                else
                    chk("out_data", 64'(out_data), 64'(sb.pop_front()));
            end
            if (res_valid && res_ready)
                sb.push_back(res_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        res_valid = 1'b0;
        res_data = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_res_ready", 64'(res_ready), 64'd1);
        chk("rst_drop", 64'(drop), 64'd0);
        chk("rst_count", 64'(stat_count), 64'd0);
        chk("rst_sum", 64'(stat_sum), 64'd0);
        chk("rst_min", 64'(stat_min), 64'hFFFF_FFFF);
        chk("rst_max", 64'(stat_max), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic pushes and stats
        push_word(32'd10);
        push_word(32'd20);
        push_word(32'd30);
        chk("t1_level", 64'(level), 64'd3);
        chk("t1_out_data", 64'(out_data), 64'd10);
        chk("t1_count", 64'(stat_count), 64'd3);
        chk("t1_sum", 64'(stat_sum), 64'd60);
        chk("t1_min", 64'(stat_min), 64'd10);
        chk("t1_max", 64'(stat_max), 64'd30);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        chk("t1_drained", 64'(level), 64'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t1_clr_count", 64'(stat_count), 64'd0);

        // Fill and overflow
        res_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            res_data = 32'(i);
            tick();
            if (i == 8)
                chk("t2_full_ready", 64'(res_ready), 64'd0);
            if (i == 9)
                chk("t2_drop", 64'(drop), 64'd1);
        end
        res_valid = 1'b0;
        tick();
        chk("t2_drop_end", 64'(drop), 64'd0);
        chk("t2_level", 64'(level), 64'd8);
        chk("t2_sum", 64'(stat_sum), 64'd36);
        chk("t2_count", 64'(stat_count), 64'd8);
        chk("t2_max", 64'(stat_max), 64'd8);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        chk("t2_level4", 64'(level), 64'd4);

        // Concurrent push/pop with pointer wrap
        res_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            res_data = 32'(100 + i);
            tick();
            chk("t3_level", 64'(level), 64'd4);
        end
        res_valid = 1'b0;
        repeat (4) tick();
        out_ready = 1'b0;
        chk("t3_drained", 64'(level), 64'd0);

        // Empty FIFO: push with out_ready high does not pop
        res_valid = 1'b1;
        res_data = 32'd15;
        out_ready = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("t4_out_valid", 64'(out_valid), 64'd1);
        chk("t4_out_data", 64'(out_data), 64'd15);
        chk("t4_level", 64'(level), 64'd1);
        tick();
        out_ready = 1'b0;
        chk("t4_level0", 64'(level), 64'd0);

        // Clear beats a simultaneous push
        push_word(32'd7);
        push_word(32'd8);
        clear = 1'b1;
        res_valid = 1'b1;
        res_data = 32'hFFFF_FFFF;
        tick();
        clear = 1'b0;
        res_valid = 1'b0;
        chk("t5_level", 64'(level), 64'd0);
        chk("t5_count", 64'(stat_count), 64'd0);
        chk("t5_sum", 64'(stat_sum), 64'd0);
        chk("t5_max", 64'(stat_max), 64'd0);
        chk("t5_min", 64'(stat_min), 64'hFFFF_FFFF);
        chk("t5_drop", 64'(drop), 64'd0);
        push_word(32'd5);
        chk("t5_min5", 64'(stat_min), 64'd5);
        chk("t5_max5", 64'(stat_max), 64'd5);
        chk("t5_count1", 64'(stat_count), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset between edges
        for (int i = 0; i < 6; i++)
            push_word(32'(200 + i));
        chk("t6_level6", 64'(level), 64'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_out_data", 64'(out_data), 64'd0);
        chk("t6_res_ready", 64'(res_ready), 64'd1);
        chk("t6_count", 64'(stat_count), 64'd0);
        chk("t6_sum", 64'(stat_sum), 64'd0);
        chk("t6_min", 64'(stat_min), 64'hFFFF_FFFF);
        chk("t6_max", 64'(stat_max), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        push_word(32'd42);
        chk("t6_after", 64'(out_data), 64'd42);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("sb_left", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
